knob_mode_ctrl: RTL



---
 rtl/knob_mode_ctrl_pkg.sv | 38 +++
 rtl/knob_mode_ctrl_if.sv | 24 ++
 rtl/button_debounce.sv | 47 ++++
 rtl/knob_mode_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/knob_mode_ctrl_pkg.sv
// Shared types for the rotary-encoder front end: mode codes, FSM state and
// the quadrature step classifier.
package knob_pkg;

    localparam logic [1:0] MODE_FREQ = 2'b00;
    localparam logic [1:0] MODE_AMP  = 2'b01;
    localparam logic [1:0] MODE_MUTE = 2'b10;

    typedef enum logic [1:0] {
        ST_FREQ = MODE_FREQ,
        ST_AMP  = MODE_AMP,
        ST_MUTE = MODE_MUTE
    } mode_state_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'b00,
        STEP_CW      = 2'b01,
        STEP_CCW     = 2'b10,
        STEP_ILLEGAL = 2'b11
    } quad_step_t;

    // Gray order 00->01->11->10->00 is clockwise; both bits flipping is illegal.
    function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] curr);
        quad_step_t r;
        if (prev == curr) begin
            r = STEP_NONE;
        end else if ((prev ^ curr) == 2'b11) begin
            r = STEP_ILLEGAL;
        end else begin
            case ({prev, curr})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: r = STEP_CW;
                default:                             r = STEP_CCW;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/knob_mode_ctrl_if.sv
// Encoder/button front-end signal bundle: raw encoder/button inputs and the
// tick/enable outputs that feed the frequency and amplitude counters.
interface knob_mode_ctrl_if;
    logic       enc_a;
    logic       enc_b;
    logic       btn;
    logic       enc_tick;
    logic       enc_dir;
    logic       f_en;
    logic       a_en;
    logic       mute;
    logic [1:0] mode;
    logic       enc_err;

    modport master (
        output enc_a, enc_b, btn,
        input  enc_tick, enc_dir, f_en, a_en, mute, mode, enc_err
    );

    modport slave (
        input  enc_a, enc_b, btn,
        output enc_tick, enc_dir, f_en, a_en, mute, mode, enc_err
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button synchronizer and debouncer; emits a one-cycle press pulse
// when the accepted level goes from released to pressed.
module button_debounce
    import knob_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    logic             btn_s1;
    logic             btn_s2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            // Count only while the input disagrees with the accepted level.
            if (btn_s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= btn_s2;
                press <= btn_s2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/knob_mode_ctrl.sv
// Rotary-encoder UI controller: quadrature decode to per-detent ticks, button
// press handling and the FREQ/AMP/MUTE mode machine driving counter enables.
module knob_mode_ctrl
    import knob_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned STEPS_PER_DETENT = 4
) (
    input  logic              clk,
    input  logic              reset,
    knob_mode_ctrl_if.slave   io
);

    localparam int unsigned              SUB_W   = $clog2(STEPS_PER_DETENT) + 1;
    localparam logic signed [SUB_W-1:0]  SUB_ONE = SUB_W'(1);
    localparam logic signed [SUB_W-1:0]  SUB_MAX = SUB_W'(STEPS_PER_DETENT - 1);
    localparam logic signed [SUB_W-1:0]  SUB_MIN = -SUB_MAX;

    logic [1:0]              ab_s1, ab_s2, ab_prev;
    logic signed [SUB_W-1:0] sub_cnt, sub_nxt;
    quad_step_t              step;
    logic                    det_cw, det_ccw;
    logic                    tick_pending, tick, dir, err;
    logic                    press, press_pending, advance;
    mode_state_t             state, state_nxt;
    logic                    f_en_r, a_en_r, mute_r;
    logic                    f_en_nxt, a_en_nxt, mute_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (io.btn),
        .press (press)
    );

    always_comb begin
        step    = quad_step(ab_prev, ab_s2);
        sub_nxt = sub_cnt;
        det_cw  = 1'b0;
        det_ccw = 1'b0;
        case (step)
            STEP_CW: begin
                if (sub_cnt == SUB_MAX) begin
                    sub_nxt = '0;
                    det_cw  = 1'b1;
                end else begin
                    sub_nxt = sub_cnt + SUB_ONE;
                end
            end
            STEP_CCW: begin
                if (sub_cnt == SUB_MIN) begin
                    sub_nxt = '0;
                    det_ccw = 1'b1;
                end else begin
                    sub_nxt = sub_cnt - SUB_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ab_s1        <= '0;
            ab_s2        <= '0;
            ab_prev      <= '0;
            sub_cnt      <= '0;
            err          <= 1'b0;
            dir          <= 1'b0;
            tick         <= 1'b0;
            tick_pending <= 1'b0;
        end else begin
            ab_s1   <= {io.enc_a, io.enc_b};
            ab_s2   <= ab_s1;
            ab_prev <= ab_s2;
            sub_cnt <= sub_nxt;
            err     <= (step == STEP_ILLEGAL);
            if (det_cw) begin
                dir <= 1'b1;
            end else if (det_ccw) begin
                dir <= 1'b0;
            end
            // A detent landing while a tick is being issued re-arms pending,
            // so the following tick is separated by at least one low cycle.
            tick <= tick_pending && !tick;
            if (det_cw || det_ccw) begin
                tick_pending <= 1'b1;
            end else if (tick_pending && !tick) begin
                tick_pending <= 1'b0;
            end
        end
    end

    assign advance = press_pending && !tick_pending && !tick;

    always_comb begin
        state_nxt = state;
        if (advance) begin
            case (state)
                ST_FREQ: state_nxt = ST_AMP;
                ST_AMP:  state_nxt = ST_MUTE;
                default: state_nxt = ST_FREQ;
            endcase
        end
        f_en_nxt = (state_nxt == ST_FREQ);
        a_en_nxt = (state_nxt == ST_AMP);
        mute_nxt = (state_nxt == ST_MUTE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_FREQ;
            f_en_r        <= 1'b1;
            a_en_r        <= 1'b0;
            mute_r        <= 1'b0;
            press_pending <= 1'b0;
        end else begin
            state  <= state_nxt;
            f_en_r <= f_en_nxt;
            a_en_r <= a_en_nxt;
            mute_r <= mute_nxt;
            if (press) begin
                press_pending <= 1'b1;
            end else if (advance) begin
                press_pending <= 1'b0;
            end
        end
    end

    assign io.enc_tick = tick;
    assign io.enc_dir  = dir;
    assign io.enc_err  = err;
    assign io.f_en     = f_en_r;
    assign io.a_en     = a_en_r;
    assign io.mute     = mute_r;
    assign io.mode     = state;

endmodule
